// File: rtl/weight_stream_pkg.sv
// Shared state type, default widths and derived width constants for the weight stream loader.
package weight_stream_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_LEN_WIDTH  = 24;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int MAX_CH         = 16;

    // The tag is sized for the largest supported channel count so every build shares one width.
    localparam int CH_IDX_W = $clog2(MAX_CH);
    localparam int CNT_W    = $clog2(DEF_FIFO_DEPTH) + 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wsl_chan_fifo.sv
// Single-clock per-channel word FIFO; head is forced to zero while empty.
module wsl_chan_fifo
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH,
    parameter int CW         = CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Round-robin feeder sharing one weight-memory read port across NUM_CH consumer FIFOs.
// Optional abort input enabled by defining WEIGHT_STREAM_LOADER_ABORT_EN.
module weight_stream_loader
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  cfg_len,
`ifdef WEIGHT_STREAM_LOADER_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         mem_rd_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rd_data,
    output logic [NUM_CH-1:0]            w_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] w_data,
    input  logic [NUM_CH-1:0]            w_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q [NUM_CH];
    logic [LEN_WIDTH-1:0]  rem_q  [NUM_CH];
    logic [CH_IDX_W-1:0]   rr_ptr;
    logic [CH_IDX_W-1:0]   tag_q;
    logic [CH_IDX_W-1:0]   grant_idx;
    logic                  inflight_q;
    logic                  grant_valid;
    logic                  abort_req;
    logic                  all_issued;
    logic                  all_empty;
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     fifo_push;
    logic [NUM_CH-1:0]     fifo_empty;
    logic [NUM_CH-1:0]     fifo_full;
    logic [CW-1:0]         fifo_count [NUM_CH];
    logic [DATA_WIDTH-1:0] fifo_head  [NUM_CH];

`ifdef WEIGHT_STREAM_LOADER_ABORT_EN
    assign abort_req = abort && ((state == RUN) || (state == DRAIN));
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (abort_req) state_next = IDLE;
                     else if (all_issued) state_next = DRAIN;
            DRAIN:   if (abort_req) state_next = IDLE;
                     else if (!inflight_q && all_empty) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, DRAIN: busy = 1'b1;
            FIN:        done = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        all_issued = 1'b1;
        all_empty  = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rem_q[c] != '0) all_issued = 1'b0;
            if (!fifo_empty[c]) all_empty = 1'b0;
        end
    end

    // A read still in flight reserves its FIFO slot, so a returning word always finds room.
    always_comb begin
        eligible    = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        mem_addr    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = (state == RUN) && !abort_req && (rem_q[c] != '0) &&
                (({1'b0, fifo_count[c]} + (CW+1)'(inflight_q && (tag_q == CH_IDX_W'(c))))
                 < (CW+1)'(FIFO_DEPTH));
        end
        for (int k = 0; k < NUM_CH; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!grant_valid && eligible[c] && (c == (int'(rr_ptr) + k) % NUM_CH)) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_IDX_W'(c);
                    mem_addr    = addr_q[c];
                end
            end
        end
    end

    assign mem_rd_en = grant_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                addr_q[c] <= '0;
                rem_q[c]  <= '0;
            end
            rr_ptr     <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= grant_valid;
            if (grant_valid) begin
                tag_q  <= grant_idx;
                rr_ptr <= (grant_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_IDX_W'(1);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if ((state == IDLE) && start) begin
                    addr_q[c] <= cfg_base[c*ADDR_WIDTH +: ADDR_WIDTH];
                    rem_q[c]  <= cfg_len[c*LEN_WIDTH +: LEN_WIDTH];
                end else if (grant_valid && (grant_idx == CH_IDX_W'(c))) begin
                    addr_q[c] <= addr_q[c] + ADDR_WIDTH'(1);
                    rem_q[c]  <= rem_q[c] - LEN_WIDTH'(1);
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
            assign fifo_push[c] = inflight_q && (tag_q == CH_IDX_W'(c));

            wsl_chan_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (FIFO_DEPTH),
                .CW         (CW)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .flush     (abort_req),
                .push      (fifo_push[c]),
                .push_data (mem_rd_data),
                .pop       (w_valid[c] && w_ready[c]),
                .head      (fifo_head[c]),
                .count     (fifo_count[c]),
                .empty     (fifo_empty[c]),
                .full      (fifo_full[c])
            );

            assign w_valid[c]                          = !fifo_empty[c];
            assign w_data[c*DATA_WIDTH +: DATA_WIDTH] = fifo_head[c];

            always @(posedge clk) begin
                if (reset && !abort_req) begin
                    assert (!(fifo_push[c] && fifo_full[c]));
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader with a mem[a]=a memory model and per-channel capture.
module tb_weight_stream_loader;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_CH     = 4;
    localparam int ADDR_WIDTH = 24;
    localparam int LEN_WIDTH  = 24;
    localparam int FIFO_DEPTH = 4;

    logic                         clk         = 1'b0;
    logic                         reset       = 1'b0;
    logic                         start       = 1'b0;
    logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base    = '0;
    logic [NUM_CH*LEN_WIDTH-1:0]  cfg_len     = '0;
    logic                         mem_rd_en;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]        mem_rd_data = '0;
    logic [NUM_CH-1:0]            w_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] w_data;
    logic [NUM_CH-1:0]            w_ready     = '1;
    logic                         busy;
    logic                         done;
`ifdef WEIGHT_STREAM_LOADER_ABORT_EN
    logic                         abort       = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DATA_WIDTH-1:0] rx_data [NUM_CH][32];
    int rx_cnt [NUM_CH];
    logic [ADDR_WIDTH-1:0] rd_log [64];
    int rd_cnt, ch1_rd, done_cnt, busy_cnt, first_valid_cyc, start_cyc, other_valid_cnt;
    int rr_exp [8] = '{0, 1000, 2000, 3000, 1, 1001, 2001, 3001};

    weight_stream_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CH     (NUM_CH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_base    (cfg_base),
        .cfg_len     (cfg_len),
`ifdef WEIGHT_STREAM_LOADER_ABORT_EN
        .abort       (abort),
`endif
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Weight memory whose content equals its address, answering one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= DATA_WIDTH'(mem_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        for (int c = 0; c < NUM_CH; c++) rx_cnt[c] = 0;
        rd_cnt = 0; ch1_rd = 0; done_cnt = 0; busy_cnt = 0;
        first_valid_cyc = -1; other_valid_cnt = 0;
    endtask

    task automatic sampleOutputs();
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_valid[c] && w_ready[c]) begin
                if (rx_cnt[c] < 32) rx_data[c][rx_cnt[c]] = w_data[c*DATA_WIDTH +: DATA_WIDTH];
                rx_cnt[c]++;
            end
        end
        if (mem_rd_en) begin
            if (rd_cnt < 64) rd_log[rd_cnt] = mem_addr;
            rd_cnt++;
            if (mem_addr >= 24'd1000 && mem_addr < 24'd2000) ch1_rd++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if ((|w_valid) && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (|w_valid[NUM_CH-1:1]) other_valid_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        clearMonitor();
    endtask

    task automatic applyStimulus(input logic [NUM_CH*ADDR_WIDTH-1:0] base,
                                 input logic [NUM_CH*LEN_WIDTH-1:0] len);
        cfg_base = base;
        cfg_len  = len;
        clearMonitor();
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(done_cnt > 0), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_rd_en"}, mem_rd_en, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_w_valid"}, w_valid, 0);
        checkOutput({tag, "_w_data"}, w_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    initial begin
        clearMonitor();
        tick();
        tick();
        checkResetOutputs("rst");
        reset = 1'b1;
        tick();

        $display("[TB] single channel");
        applyStimulus({24'd0, 24'd0, 24'd0, 24'd100}, {24'd0, 24'd0, 24'd0, 24'd3});
        waitDone("single_done_seen", 100);
        repeat (5) tick();
        checkOutput("single_latency", 64'(first_valid_cyc - start_cyc), 3);
        checkOutput("single_rx_cnt", rx_cnt[0], 3);
        for (int i = 0; i < 3; i++) checkOutput("single_rx_data", rx_data[0][i], 100 + i);
        checkOutput("single_other_valid", other_valid_cnt, 0);
        checkOutput("single_done_cnt", done_cnt, 1);
        checkOutput("single_reads", rd_cnt, 3);

        $display("[TB] round robin");
        doReset();
        applyStimulus({24'd3000, 24'd2000, 24'd1000, 24'd0}, {24'd2, 24'd2, 24'd2, 24'd2});
        waitDone("rr_done_seen", 100);
        checkOutput("rr_reads", rd_cnt, 8);
        for (int i = 0; i < 8; i++) checkOutput("rr_addr_order", rd_log[i], rr_exp[i]);
        for (int c = 0; c < NUM_CH; c++) begin
            checkOutput("rr_rx_cnt", rx_cnt[c], 2);
            for (int i = 0; i < 2; i++) checkOutput("rr_rx_data", rx_data[c][i], c * 1000 + i);
        end

        $display("[TB] backpressure");
        doReset();
        w_ready = 4'b1101;
        applyStimulus({24'd3000, 24'd2000, 24'd1000, 24'd0}, {24'd3, 24'd3, 24'd10, 24'd3});
        repeat (19) tick();
        checkOutput("bp_ch1_reads_stalled", ch1_rd, FIFO_DEPTH);
        checkOutput("bp_total_reads", rd_cnt, 13);
        checkOutput("bp_ch1_rx_stalled", rx_cnt[1], 0);
        checkOutput("bp_ch1_valid", w_valid[1], 1);
        checkOutput("bp_ch0_rx", rx_cnt[0], 3);
        checkOutput("bp_ch2_rx", rx_cnt[2], 3);
        checkOutput("bp_ch3_rx", rx_cnt[3], 3);
        checkOutput("bp_not_done", done_cnt, 0);
        w_ready = 4'b1111;
        waitDone("bp_done_seen", 200);
        repeat (3) tick();
        checkOutput("bp_ch1_rx", rx_cnt[1], 10);
        for (int i = 0; i < 10; i++) checkOutput("bp_ch1_data", rx_data[1][i], 1000 + i);
        checkOutput("bp_ch1_reads", ch1_rd, 10);
        checkOutput("bp_done_cnt", done_cnt, 1);

        $display("[TB] zero length");
        doReset();
        applyStimulus({24'd3000, 24'd2000, 24'd1000, 24'd0}, '0);
        waitDone("zero_done_seen", 20);
        repeat (3) tick();
        checkOutput("zero_busy_cycles", busy_cnt, 2);
        checkOutput("zero_done_cnt", done_cnt, 1);
        checkOutput("zero_reads", rd_cnt, 0);

        $display("[TB] start while busy");
        doReset();
        applyStimulus({24'd0, 24'd0, 24'd0, 24'd200}, {24'd0, 24'd0, 24'd0, 24'd4});
        tick();
        tick();
        cfg_base = {24'd0, 24'd0, 24'd0, 24'd500};
        cfg_len  = {24'd0, 24'd0, 24'd0, 24'd2};
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone("busy_start_done_seen", 100);
        repeat (10) tick();
        checkOutput("busy_start_rx_cnt", rx_cnt[0], 4);
        for (int i = 0; i < 4; i++) checkOutput("busy_start_rx_data", rx_data[0][i], 200 + i);
        checkOutput("busy_start_done_cnt", done_cnt, 1);
        checkOutput("busy_start_reads", rd_cnt, 4);

        $display("[TB] reset mid-run");
        doReset();
        applyStimulus({24'd0, 24'd0, 24'd0, 24'd300}, {24'd0, 24'd0, 24'd0, 24'd10});
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkResetOutputs("midrst");
        reset = 1'b1;
        tick();
        applyStimulus({24'd0, 24'd0, 24'd0, 24'd600}, {24'd0, 24'd0, 24'd0, 24'd3});
        waitDone("midrst_done_seen", 100);
        repeat (3) tick();
        checkOutput("midrst_latency", 64'(first_valid_cyc - start_cyc), 3);
        checkOutput("midrst_rx_cnt", rx_cnt[0], 3);
        for (int i = 0; i < 3; i++) checkOutput("midrst_rx_data", rx_data[0][i], 600 + i);
        checkOutput("midrst_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
